bmp_header_parser: RTL and testbench
====================================

// Module: bmp_header_parser
// PURPOSE
//  Front-end stage of the crop pipeline. On start, reads the BMP header from the
//  input image byte memory and emits the decoded image geometry to the bounding-box/crop core.
//  Fields emitted: width, |height|, scan orientation, pixel-data offset, padded row stride.
//  Rejects malformed or unsupported headers with an error code, so the core never runs on bad data.
// PARAMETERS
//  ADDR_W   18  byte-address width of image memory
//  DIM_W    12  width of width/height outputs; larger dimensions are rejected
//  RD_LAT   1   image memory read latency in cycles (1..3)
// PORTS
//  CLOCK_50     in   1        system clock
//  rst_n        in   1        async active-low reset (driven from KEY[3])
//  start        in   1        1-cycle pulse; begin parse (ignored unless IDLE/DONE/ERR)
//  mem_addr     out  ADDR_W   byte address to image memory
//  mem_rd       out  1        read strobe; data valid RD_LAT cycles later
//  mem_rdata    in   8        read byte
//  busy         out  1        high from start accept until DONE/ERR
//  hdr_valid    out  1        level; geometry outputs valid, held until next start
//  hdr_err      out  1        level; parse failed, held until next start
//  err_code     out  3        0 none,1 sig,2 bpp,3 dim,4 offset,5 planes,6 compr,7 dib
//  img_width    out  DIM_W    pixels per row
//  img_height   out  DIM_W    |biHeight|
//  top_down     out  1        1 when biHeight negative
//  bpp          out  6        24 or 32
//  data_offset  out  ADDR_W   bfOffBits
//  row_stride   out  ADDR_W+1 bytes per row, padded to multiple of 4
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; reset mid-parse aborts immediately, no partial valid.
//  FSM: IDLE -start-> FETCH -34 issued-> DRAIN -last byte back-> CALC -> DONE | ERR.
//   DONE/ERR -start-> FETCH (clears hdr_valid/hdr_err/err_code same edge).
//  FETCH issues mem_rd every cycle, addr 0..33 ascending; one outstanding-byte counter on
//   return side assembles little-endian fields (bytes 0-1 sig, 10-13 offset, 14-17 dib size,
//   18-21 width, 22-25 height, 26-27 planes, 28-29 bpp, 30-33 compression).
//  Latency: start edge to hdr_valid/hdr_err rise = 34 + RD_LAT + 2 cycles, fixed.
//  CALC checks in priority: sig!="BM"->1; bpp not 24/32->2; width==0, width>=2^DIM_W,
//   height==0, |height|>=2^DIM_W ->3; offset<54 or offset>=2^ADDR_W ->4.
//  Height: two's complement 32-bit; negative -> negate, top_down=1. -2^31 -> err 3.
//  row_stride = ((width*bpp/8)+3) & ~3, computed in ADDR_W+1 bits, no truncation for legal dims.
//  start while busy: ignored. mem_rd never asserted outside FETCH.
// CONFIGURATION
//  BMP_STRICT_EN defined: also planes!=1 ->5, compression!=0 (32bpp: !=0 and !=3) ->6,
//   dib size<40 ->7; checked after code 4.
//  Undefined: codes 5-7 never produced; those bytes still fetched (latency unchanged).
// STRUCTURE
//  Package bmp_pkg: header field byte offsets, BMP_SIG (16'h4D42), BMP_MIN_HDR=54,
//   err_code enum, parser state enum; shared with the downstream header writer.
//  One sub-module: bmp_le_field_capture (byte index + data -> 32-bit LE field registers).
// TESTING
//  40x40 24bpp, offset 54 -> hdr_valid at start+37 (RD_LAT=1), stride 120, top_down 0.
//  41x17 24bpp -> stride 124; 41x17 32bpp -> stride 164.
//  height=-30 (0xFFFFFFE2) -> img_height 30, top_down 1.
//  bytes 0-1 = "BA" -> hdr_err, err_code 1; bpp 8 -> err_code 2; width 4096 -> err_code 3.
//  rst_n low at cycle 10 of FETCH -> outputs 0, mem_rd 0; fresh start gives correct result.
//  BMP_STRICT_EN: planes=2 -> err_code 5; without macro same header -> hdr_valid.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared BMP header definitions: field byte offsets, size limits, error codes and parser states.
// Also used by the downstream header writer.
package bmp_pkg;

    localparam logic [15:0] BMP_SIG     = 16'h4D42;
    localparam logic [31:0] BMP_MIN_HDR = 32'd54;
    localparam logic [5:0]  HDR_LAST    = 6'd33;

    localparam logic [5:0] OFS_SIG    = 6'd0;
    localparam logic [5:0] OFS_OFFSET = 6'd10;
    localparam logic [5:0] OFS_DIB    = 6'd14;
    localparam logic [5:0] OFS_WIDTH  = 6'd18;
    localparam logic [5:0] OFS_HEIGHT = 6'd22;
    localparam logic [5:0] OFS_PLANES = 6'd26;
    localparam logic [5:0] OFS_BPP    = 6'd28;
    localparam logic [5:0] OFS_COMPR  = 6'd30;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_SIG    = 3'd1,
        ERR_BPP    = 3'd2,
        ERR_DIM    = 3'd3,
        ERR_OFFSET = 3'd4,
        ERR_PLANES = 3'd5,
        ERR_COMPR  = 3'd6,
        ERR_DIB    = 3'd7
    } bmp_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_CALC,
        ST_DONE,
        ST_ERR
    } bmp_state_e;

    function automatic logic field_hit(input logic [5:0] idx, input logic [5:0] base,
                                       input logic [2:0] len);
        return (idx >= base) && (idx < base + 6'(len));
    endfunction

    function automatic logic [1:0] field_lane(input logic [5:0] idx, input logic [5:0] base);
        return 2'(idx - base);
    endfunction

endpackage

// File: rtl/bmp_header_parser_if.sv
// Parser-side bundle: image-memory read port, start/status handshake and decoded geometry.
interface bmp_header_parser_if #(
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 12
);
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              hdr_valid;
    logic              hdr_err;
    logic [2:0]        err_code;
    logic [DIM_W-1:0]  img_width;
    logic [DIM_W-1:0]  img_height;
    logic              top_down;
    logic [5:0]        bpp;
    logic [ADDR_W-1:0] data_offset;
    logic [ADDR_W:0]   row_stride;

    modport master (
        input  start, mem_rdata,
        output mem_addr, mem_rd, busy, hdr_valid, hdr_err, err_code,
               img_width, img_height, top_down, bpp, data_offset, row_stride
    );

    modport slave (
        output start, mem_rdata,
        input  mem_addr, mem_rd, busy, hdr_valid, hdr_err, err_code,
               img_width, img_height, top_down, bpp, data_offset, row_stride
    );
endinterface

// File: rtl/bmp_le_field_capture.sv
// Steers each returned header byte (by index) into its little-endian field register.
module bmp_le_field_capture
    import bmp_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [5:0]  i_idx,
    input  logic [7:0]  i_data,
    output logic [15:0] o_sig,
    output logic [31:0] o_offset,
    output logic [31:0] o_dib,
    output logic [31:0] o_width,
    output logic [31:0] o_height,
    output logic [15:0] o_planes,
    output logic [15:0] o_bpp,
    output logic [31:0] o_compr
);
    logic [1:0][7:0] r_sig, r_planes, r_bpp;
    logic [3:0][7:0] r_offset, r_dib, r_width, r_height, r_compr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig    <= '0;
            r_planes <= '0;
            r_bpp    <= '0;
            r_offset <= '0;
            r_dib    <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_compr  <= '0;
        end else if (i_valid) begin
            if (field_hit(i_idx, OFS_SIG, 3'd2))    r_sig[1'(field_lane(i_idx, OFS_SIG))]       <= i_data;
            if (field_hit(i_idx, OFS_OFFSET, 3'd4)) r_offset[field_lane(i_idx, OFS_OFFSET)]     <= i_data;
            if (field_hit(i_idx, OFS_DIB, 3'd4))    r_dib[field_lane(i_idx, OFS_DIB)]           <= i_data;
            if (field_hit(i_idx, OFS_WIDTH, 3'd4))  r_width[field_lane(i_idx, OFS_WIDTH)]       <= i_data;
            if (field_hit(i_idx, OFS_HEIGHT, 3'd4)) r_height[field_lane(i_idx, OFS_HEIGHT)]     <= i_data;
            if (field_hit(i_idx, OFS_PLANES, 3'd2)) r_planes[1'(field_lane(i_idx, OFS_PLANES))] <= i_data;
            if (field_hit(i_idx, OFS_BPP, 3'd2))    r_bpp[1'(field_lane(i_idx, OFS_BPP))]       <= i_data;
            if (field_hit(i_idx, OFS_COMPR, 3'd4))  r_compr[field_lane(i_idx, OFS_COMPR)]       <= i_data;
        end
    end

    assign o_sig    = r_sig;
    assign o_offset = r_offset;
    assign o_dib    = r_dib;
    assign o_width  = r_width;
    assign o_height = r_height;
    assign o_planes = r_planes;
    assign o_bpp    = r_bpp;
    assign o_compr  = r_compr;
endmodule

// File: rtl/bmp_header_parser.sv
// Reads the 34-byte BMP header from image memory, validates it and emits crop geometry.
// Define BMP_STRICT_EN to also reject bad planes / compression / DIB size (codes 5-7).
module bmp_header_parser
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 12,
    parameter int RD_LAT = 1
) (
    input logic                 CLOCK_50,
    input logic                 rst_n,
    bmp_header_parser_if.master bus
);
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic              r_ret_vld;
    logic [7:0]        r_ret_data;
    logic [5:0]        r_ret_idx;
    bmp_state_e        r_state;
    bmp_err_e          r_err_code;
    logic              r_busy, r_hdr_valid, r_hdr_err, r_top_down;
    logic [DIM_W-1:0]  r_img_width, r_img_height;
    logic [5:0]        r_bpp;
    logic [ADDR_W-1:0] r_data_offset;
    logic [ADDR_W:0]   r_row_stride;

    logic [15:0] w_sig, w_planes, w_bpp;
    logic [31:0] w_offset, w_dib, w_width, w_height, w_compr, w_abs_h;
    logic        w_neg_h, w_bpp32;
    logic [ADDR_W:0] w_w_ext, w_row_bytes, w_stride;
    bmp_err_e    w_err;

    // Return data is retimed one extra cycle before capture; this fixes start-to-result at 34+RD_LAT+2.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pipe  <= '0;
            r_ret_vld  <= 1'b0;
            r_ret_data <= '0;
        end else begin
            r_rd_pipe  <= RD_LAT'({r_rd_pipe, r_mem_rd});
            r_ret_vld  <= r_rd_pipe[RD_LAT-1];
            r_ret_data <= bus.mem_rdata;
        end
    end

    bmp_le_field_capture u_capture (
        .i_clk    (CLOCK_50),
        .i_rst_n  (rst_n),
        .i_valid  (r_ret_vld),
        .i_idx    (r_ret_idx),
        .i_data   (r_ret_data),
        .o_sig    (w_sig),
        .o_offset (w_offset),
        .o_dib    (w_dib),
        .o_width  (w_width),
        .o_height (w_height),
        .o_planes (w_planes),
        .o_bpp    (w_bpp),
        .o_compr  (w_compr)
    );

    always_comb begin
        w_neg_h     = w_height[31];
        w_abs_h     = w_neg_h ? (~w_height + 32'd1) : w_height;
        w_bpp32     = (w_bpp == 16'd32);
        w_w_ext     = (ADDR_W+1)'(w_width[DIM_W-1:0]);
        w_row_bytes = w_bpp32 ? (w_w_ext << 2) : ((w_w_ext << 1) + w_w_ext);
        w_stride    = (w_row_bytes + (ADDR_W+1)'(3)) & {{(ADDR_W-1){1'b1}}, 2'b00};
        w_err       = ERR_NONE;
        if (w_sig != BMP_SIG)
            w_err = ERR_SIG;
        else if (w_bpp != 16'd24 && !w_bpp32)
            w_err = ERR_BPP;
        else if (w_width == '0 || w_width[31:DIM_W] != '0 || w_abs_h == '0 || w_abs_h[31:DIM_W] != '0)
            w_err = ERR_DIM;
        else if (w_offset < BMP_MIN_HDR || w_offset[31:ADDR_W] != '0)
            w_err = ERR_OFFSET;
`ifdef BMP_STRICT_EN
        else if (w_planes != 16'd1)
            w_err = ERR_PLANES;
        else if (w_compr != '0 && !(w_bpp32 && w_compr == 32'd3))
            w_err = ERR_COMPR;
        else if (w_dib < 32'd40)
            w_err = ERR_DIB;
`endif
    end

`ifndef BMP_STRICT_EN
    logic w_unused_strict;
    assign w_unused_strict = ^{w_planes, w_compr, w_dib};
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_ret_idx     <= '0;
            r_busy        <= 1'b0;
            r_hdr_valid   <= 1'b0;
            r_hdr_err     <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_img_width   <= '0;
            r_img_height  <= '0;
            r_top_down    <= 1'b0;
            r_bpp         <= '0;
            r_data_offset <= '0;
            r_row_stride  <= '0;
        end else begin
            if (r_ret_vld)
                r_ret_idx <= r_ret_idx + 6'd1;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.start) begin
                        r_state       <= ST_FETCH;
                        r_mem_rd      <= 1'b1;
                        r_mem_addr    <= '0;
                        r_ret_idx     <= '0;
                        r_busy        <= 1'b1;
                        r_hdr_valid   <= 1'b0;
                        r_hdr_err     <= 1'b0;
                        r_err_code    <= ERR_NONE;
                        r_img_width   <= '0;
                        r_img_height  <= '0;
                        r_top_down    <= 1'b0;
                        r_bpp         <= '0;
                        r_data_offset <= '0;
                        r_row_stride  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (r_mem_addr == ADDR_W'(HDR_LAST)) begin
                        r_mem_rd <= 1'b0;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_ret_vld && r_ret_idx == HDR_LAST)
                        r_state <= ST_CALC;
                end
                ST_CALC: begin
                    r_busy <= 1'b0;
                    if (w_err != ERR_NONE) begin
                        r_state    <= ST_ERR;
                        r_hdr_err  <= 1'b1;
                        r_err_code <= w_err;
                    end else begin
                        r_state       <= ST_DONE;
                        r_hdr_valid   <= 1'b1;
                        r_img_width   <= w_width[DIM_W-1:0];
                        r_img_height  <= w_abs_h[DIM_W-1:0];
                        r_top_down    <= w_neg_h;
                        r_bpp         <= w_bpp[5:0];
                        r_data_offset <= w_offset[ADDR_W-1:0];
                        r_row_stride  <= w_stride;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.busy        = r_busy;
    assign bus.hdr_valid   = r_hdr_valid;
    assign bus.hdr_err     = r_hdr_err;
    assign bus.err_code    = r_err_code;
    assign bus.img_width   = r_img_width;
    assign bus.img_height  = r_img_height;
    assign bus.top_down    = r_top_down;
    assign bus.bpp         = r_bpp;
    assign bus.data_offset = r_data_offset;
    assign bus.row_stride  = r_row_stride;
endmodule

// File: tb/tb_bmp_header_parser.sv
// Self-checking bench for bmp_header_parser: directed and randomized headers against a field-level model.
module tb_bmp_header_parser;
    localparam int ADDR_W = 18;
    localparam int DIM_W  = 12;
    localparam int RD_LAT = 1;
    localparam int LAT    = 34 + RD_LAT + 2;

    typedef struct {
        logic [15:0] sig;
        logic [31:0] offset, dib, width, height;
        logic [15:0] planes, bpp;
        logic [31:0] compr;
    } hdr_t;

    typedef struct {
        bit valid;
        int code;
        int width;
        int height;
        bit td;
        int bpp;
        int offset;
        int stride;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   rd_outside = 0;
    int   rd_addrs[$];
    logic [7:0] mem [0:63];

    bmp_header_parser_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    bmp_header_parser #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Image memory with one-cycle registered read; also logs every address requested.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem[bus.mem_addr[5:0]];
            rd_addrs.push_back(int'(bus.mem_addr));
            if (!bus.busy) rd_outside++;
        end
    end

    function automatic hdr_t good_hdr(input int w, input int h, input int bpp, input int off);
        hdr_t f;
        f.sig = 16'h4D42; f.offset = off; f.dib = 40; f.width = w; f.height = h;
        f.planes = 16'd1; f.bpp = 16'(bpp); f.compr = 0;
        return f;
    endfunction

    function automatic exp_t model(input hdr_t f);
        exp_t e;
        longint hs, ah;
        e = '{default: 0};
        hs = longint'($signed(f.height));
        ah = (hs < 0) ? -hs : hs;
        if (f.sig != 16'h4D42) e.code = 1;
        else if (!(f.bpp == 24 || f.bpp == 32)) e.code = 2;
        else if (f.width == 0 || f.width >= 4096 || ah == 0 || ah >= 4096) e.code = 3;
        else if (f.offset < 54 || f.offset >= 32'h40000) e.code = 4;
`ifdef BMP_STRICT_EN
        else if (f.planes != 1) e.code = 5;
        else if (f.compr != 0 && !(f.bpp == 32 && f.compr == 3)) e.code = 6;
        else if (f.dib < 40) e.code = 7;
`endif
        e.valid = (e.code == 0);
        if (e.valid) begin
            e.width  = int'(f.width);
            e.height = int'(ah);
            e.td     = (hs < 0);
            e.bpp    = int'(f.bpp);
            e.offset = int'(f.offset);
            e.stride = ((int'(f.width) * int'(f.bpp) / 8 + 3) / 4) * 4;
        end
        return e;
    endfunction

    function automatic hdr_t rand_hdr();
        hdr_t f;
        int h;
        h = $urandom_range(1, 4095);
        if ($urandom_range(0, 1) == 1) h = -h;
        f = good_hdr($urandom_range(1, 4095), h, ($urandom_range(0, 1) == 1) ? 32 : 24,
                     $urandom_range(54, 262143));
        if (f.bpp == 32 && $urandom_range(0, 1) == 1) f.compr = 3;
        case ($urandom_range(0, 13))
            0: f.sig    = 16'($urandom);
            1: f.bpp    = 16'($urandom_range(0, 40));
            2: f.width  = $urandom;
            3: f.width  = 0;
            4: f.height = $urandom;
            5: f.offset = $urandom_range(0, 60);
            6: f.offset = $urandom;
            7: f.planes = 16'($urandom_range(0, 3));
            8: f.compr  = $urandom_range(0, 4);
            9: f.dib    = $urandom_range(12, 130);
            default: ;
        endcase
        return f;
    endfunction

    task automatic load_hdr(input hdr_t f);
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        for (int b = 0; b < 2; b++) begin
            mem[b]      = f.sig[8*b +: 8];
            mem[26 + b] = f.planes[8*b +: 8];
            mem[28 + b] = f.bpp[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            mem[10 + b] = f.offset[8*b +: 8];
            mem[14 + b] = f.dib[8*b +: 8];
            mem[18 + b] = f.width[8*b +: 8];
            mem[22 + b] = f.height[8*b +: 8];
            mem[30 + b] = f.compr[8*b +: 8];
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit tmo);
        lat = 0;
        tmo = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (bus.hdr_valid || bus.hdr_err) begin
                lat = n;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.hdr_valid, bus.hdr_err, bus.err_code, bus.mem_rd, bus.top_down} !== '0) begin
            fails++;
            $display("FAIL reset_status: got %b required 0", {bus.busy, bus.hdr_valid, bus.hdr_err, bus.err_code, bus.mem_rd, bus.top_down});
        end
        tests++;
        if ({bus.img_width, bus.img_height, bus.bpp, bus.data_offset, bus.row_stride} !== '0) begin
            fails++;
            $display("FAIL reset_geometry: got %h required 0", {bus.img_width, bus.img_height, bus.bpp, bus.data_offset, bus.row_stride});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_headers();
        hdr_t cases[$];
        hdr_t f;
        cases.push_back(good_hdr(40, 40, 24, 54));
        cases.push_back(good_hdr(41, 17, 24, 54));
        cases.push_back(good_hdr(41, 17, 32, 54));
        cases.push_back(good_hdr(64, -30, 24, 1078));
        cases.push_back(good_hdr(4095, -4095, 32, 262143));
        cases.push_back(good_hdr(1, 1, 24, 54));
        f = good_hdr(40, 40, 24, 54); f.sig = 16'h4142;          cases.push_back(f);
        f = good_hdr(40, 40, 8, 54);                              cases.push_back(f);
        f = good_hdr(4096, 40, 24, 54);                           cases.push_back(f);
        f = good_hdr(40, 40, 24, 54); f.height = 32'h8000_0000;  cases.push_back(f);
        f = good_hdr(40, 4096, 24, 54);                           cases.push_back(f);
        f = good_hdr(40, 0, 24, 54);                              cases.push_back(f);
        f = good_hdr(40, 40, 24, 53);                             cases.push_back(f);
        f = good_hdr(40, 40, 24, 262144);                         cases.push_back(f);
        for (int r = 0; r < 24; r++) cases.push_back(rand_hdr());

        foreach (cases[i]) begin
            exp_t e;
            int   lat;
            bit   tmo, addr_ok;
            e = model(cases[i]);
            load_hdr(cases[i]);
            rd_addrs.delete();
            start_pulse();
            wait_done(lat, tmo);
            tests++;
            if (tmo || lat != LAT) begin
                fails++;
                $display("FAIL latency[%0d]: got %0d cycles (timeout=%0d) required %0d", i, lat, tmo, LAT);
            end
            tests++;
            if (bus.hdr_valid !== e.valid || bus.hdr_err !== !e.valid) begin
                fails++;
                $display("FAIL status[%0d]: got valid=%b err=%b required valid=%0d", i, bus.hdr_valid, bus.hdr_err, e.valid);
            end
            tests++;
            if (bus.err_code !== 3'(e.code)) begin
                fails++;
                $display("FAIL err_code[%0d]: got %0d required %0d", i, bus.err_code, e.code);
            end
            if (e.valid) begin
                tests++;
                if (bus.img_width !== DIM_W'(e.width) || bus.img_height !== DIM_W'(e.height)) begin
                    fails++;
                    $display("FAIL dims[%0d]: got %0dx%0d required %0dx%0d", i, bus.img_width, bus.img_height, e.width, e.height);
                end
                tests++;
                if (bus.top_down !== e.td || bus.bpp !== 6'(e.bpp)) begin
                    fails++;
                    $display("FAIL orient_bpp[%0d]: got td=%b bpp=%0d required td=%0d bpp=%0d", i, bus.top_down, bus.bpp, e.td, e.bpp);
                end
                tests++;
                if (bus.data_offset !== ADDR_W'(e.offset)) begin
                    fails++;
                    $display("FAIL offset[%0d]: got %0d required %0d", i, bus.data_offset, e.offset);
                end
                tests++;
                if (bus.row_stride !== (ADDR_W+1)'(e.stride)) begin
                    fails++;
                    $display("FAIL stride[%0d]: got %0d required %0d", i, bus.row_stride, e.stride);
                end
            end
            addr_ok = (rd_addrs.size() == 34);
            for (int k = 0; k < rd_addrs.size(); k++) if (rd_addrs[k] != k) addr_ok = 1'b0;
            tests++;
            if (!addr_ok || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL fetch[%0d]: got %0d reads busy=%b required 34 ascending reads busy=0", i, rd_addrs.size(), bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int lat;
        bit tmo;
        load_hdr(good_hdr(300, 200, 32, 54));
        start_pulse();
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if ({bus.busy, bus.hdr_valid, bus.hdr_err, bus.err_code, bus.mem_rd, bus.row_stride, bus.img_width} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b rd=%b valid=%b required all 0", bus.busy, bus.mem_rd, bus.hdr_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load_hdr(good_hdr(41, 17, 32, 54));
        start_pulse();
        wait_done(lat, tmo);
        tests++;
        if (tmo || lat != LAT || bus.hdr_valid !== 1'b1 || bus.row_stride !== 19'd164 || bus.img_width !== 12'd41) begin
            fails++;
            $display("FAIL midreset_restart: got lat=%0d valid=%b stride=%0d width=%0d required %0d/1/164/41", lat, bus.hdr_valid, bus.row_stride, bus.img_width, LAT);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit tmo;
        lat = 0;
        tmo = 1'b1;
        load_hdr(good_hdr(100, 50, 32, 1078));
        rd_addrs.delete();
        start_pulse();
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            bus.start = (n == 5);
            if (bus.hdr_valid || bus.hdr_err) begin
                lat = n;
                tmo = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (tmo || lat != LAT || rd_addrs.size() != 34) begin
            fails++;
            $display("FAIL busy_ignore: got lat=%0d reads=%0d required %0d and 34", lat, rd_addrs.size(), LAT);
        end
        tests++;
        if (bus.hdr_valid !== 1'b1 || bus.row_stride !== 19'd400) begin
            fails++;
            $display("FAIL busy_ignore_result: got valid=%b stride=%0d required 1 and 400", bus.hdr_valid, bus.row_stride);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit tmo;
        load_hdr(good_hdr(40, 40, 24, 54));
        start_pulse();
        wait_done(lat, tmo);
        load_hdr(good_hdr(40, 40, 8, 54));
        start_pulse();
        tests++;
        if (bus.hdr_valid !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_clear_valid: got valid=%b busy=%b required 0 and 1", bus.hdr_valid, bus.busy);
        end
        wait_done(lat, tmo);
        tests++;
        if (tmo || bus.hdr_err !== 1'b1 || bus.err_code !== 3'd2) begin
            fails++;
            $display("FAIL b2b_err: got err=%b code=%0d required 1 and 2", bus.hdr_err, bus.err_code);
        end
        load_hdr(good_hdr(41, 17, 24, 54));
        start_pulse();
        tests++;
        if (bus.hdr_err !== 1'b0 || bus.err_code !== 3'd0) begin
            fails++;
            $display("FAIL b2b_clear_err: got err=%b code=%0d required 0 and 0", bus.hdr_err, bus.err_code);
        end
        wait_done(lat, tmo);
        tests++;
        if (tmo || lat != LAT || bus.hdr_valid !== 1'b1 || bus.row_stride !== 19'd124) begin
            fails++;
            $display("FAIL b2b_valid: got lat=%0d valid=%b stride=%0d required %0d/1/124", lat, bus.hdr_valid, bus.row_stride, LAT);
        end
    endtask

    task automatic test_strict();
        hdr_t f[4];
        int   want[4];
        f[0] = good_hdr(40, 40, 24, 54); f[0].planes = 16'd2;
        f[1] = good_hdr(40, 40, 24, 54); f[1].compr  = 1;
        f[2] = good_hdr(40, 40, 32, 54); f[2].compr  = 3;
        f[3] = good_hdr(40, 40, 24, 54); f[3].dib    = 12;
`ifdef BMP_STRICT_EN
        want = '{5, 6, 0, 7};
`else
        want = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            int lat;
            bit tmo;
            load_hdr(f[i]);
            start_pulse();
            wait_done(lat, tmo);
            tests++;
            if (tmo || bus.err_code !== 3'(want[i]) || bus.hdr_valid !== (want[i] == 0)) begin
                fails++;
                $display("FAIL strict[%0d]: got valid=%b code=%0d required code %0d", i, bus.hdr_valid, bus.err_code, want[i]);
            end
        end
        tests++;
        if (rd_outside != 0) begin
            fails++;
            $display("FAIL stray_reads: got %0d reads while idle required 0", rd_outside);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_headers();
        test_reset_mid_fetch();
        test_busy_ignore();
        test_back_to_back();
        test_strict();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
